// File: rtl/act_sram_bcast_seq_if.sv
// rtl/act_sram_bcast_seq_if.sv - bus bundle for the broadcast activation SRAM model
// Ports (from the slave side):
//   i_csb/i_wsb/i_msb  chip select, write enable, mode (all active low except msb=1 normal)
//   i_wordmask         per-lane keep mask (1 = keep old lane)
//   i_wdata/i_waddr    write data / write (or broadcast base) address
//   i_raddr            read address
//   o_rdata/o_rvalid   pipelined read data and its valid strobe
//   o_busy             broadcast sequence in progress
//   o_err              sticky error flag
interface act_sram_bcast_seq_if #(
    parameter int LANES = 4,
    parameter int W     = 48,
    parameter int AW    = 18
);
    logic             i_csb;
    logic             i_wsb;
    logic             i_msb;
    logic [LANES-1:0] i_wordmask;
    logic [W-1:0]     i_wdata;
    logic [AW-1:0]    i_waddr;
    logic [AW-1:0]    i_raddr;
    logic [W-1:0]     o_rdata;
    logic             o_rvalid;
    logic             o_busy;
    logic             o_err;

    modport master (
        output i_csb, i_wsb, i_msb, i_wordmask, i_wdata, i_waddr, i_raddr,
        input  o_rdata, o_rvalid, o_busy, o_err
    );

    modport slave (
        input  i_csb, i_wsb, i_msb, i_wordmask, i_wdata, i_waddr, i_raddr,
        output o_rdata, o_rvalid, o_busy, o_err
    );
endinterface

// File: rtl/act_sram_bcast_seq.sv
// rtl/act_sram_bcast_seq.sv - activation SRAM model with lane-masked writes and serialised plane broadcast
// Ports:
//   clk   clock
//   rst   synchronous active-high reset (memory contents survive it)
//   bus   act_sram_bcast_seq_if.slave: csb/wsb/msb/wordmask/wdata/waddr/raddr in,
//         rdata/rvalid/busy/err out
// BCAST_PLANES must lie in 1..LANES and RD_LAT must be >= 1.
module act_sram_bcast_seq #(
    parameter int DEPTH        = 207936,
    parameter int CH_NUM       = 1,
    parameter int ACT_PER_ADDR = 4,
    parameter int BW_PER_ACT   = 12,
    parameter int PLANE_STRIDE = 3249,
    parameter int BCAST_PLANES = 4,
    parameter int RD_LAT       = 1
) (
    input logic               clk,
    input logic               rst,
    act_sram_bcast_seq_if.slave bus
);
    localparam int LANES = CH_NUM * ACT_PER_ADDR;
    localparam int W     = LANES * BW_PER_ACT;
    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = (BCAST_PLANES > 1) ? $clog2(BCAST_PLANES) : 1;
    // Plane addresses are computed wide enough that base + idx*stride never wraps,
    // so an overflowing plane is reliably seen as out of range.
    localparam int PW    = AW + $clog2(BCAST_PLANES * PLANE_STRIDE + 1) + 1;

    typedef enum logic {S_IDLE = 1'b0, S_BCAST = 1'b1} state_t;

    logic [W-1:0]      r_mem [DEPTH];

    state_t            r_state;
    logic [IW-1:0]     r_idx;
    logic [AW-1:0]     r_base;
    logic [W-1:0]      r_bdata;
    logic [LANES-1:0]  r_bmask;
    logic              r_busy;
    logic              r_err;

    logic [W-1:0]      r_pd [RD_LAT];
    logic [RD_LAT-1:0] r_pv;

    logic [W-1:0]      w_bitmask;
    logic [W-1:0]      w_bbitmask;
    logic [BW_PER_ACT-1:0] w_src_act;
    logic [W-1:0]      w_bcast_word;
    logic [PW-1:0]     w_pa;
    logic [AW-1:0]     w_pa_idx;
    logic              w_pa_ok;
    logic              w_wr_req;
    logic              w_wr_acc;
    logic              w_waddr_ok;
    logic              w_raddr_ok;
    logic              w_bcast_act;

    always_comb begin
        w_bitmask  = '0;
        w_bbitmask = '0;
        for (int k = 0; k < LANES; k++) begin
            w_bitmask[k*BW_PER_ACT +: BW_PER_ACT]  = {BW_PER_ACT{bus.i_wordmask[k]}};
            w_bbitmask[k*BW_PER_ACT +: BW_PER_ACT] = {BW_PER_ACT{r_bmask[k]}};
        end
        // Plane idx takes lane LANES-1-idx, so plane 0 gets the MSB activation.
        w_src_act = r_bdata[(LANES - 1 - int'(r_idx)) * BW_PER_ACT +: BW_PER_ACT];
    end

    assign w_bcast_word = {LANES{w_src_act}};
    assign w_pa         = PW'(r_base) + PW'(r_idx) * PW'(PLANE_STRIDE);
    assign w_pa_idx     = w_pa[AW-1:0];
    assign w_pa_ok      = w_pa < PW'(DEPTH);
    assign w_wr_req     = !bus.i_csb && !bus.i_wsb;
    assign w_wr_acc     = w_wr_req && !r_busy;
    assign w_waddr_ok   = PW'(bus.i_waddr) < PW'(DEPTH);
    assign w_raddr_ok   = PW'(bus.i_raddr) < PW'(DEPTH);
    assign w_bcast_act  = (r_state == S_BCAST);

    // Memory array. A normal write can only be accepted while idle, so it never
    // collides with a broadcast plane write on the same edge. The reset edge
    // performs no write, which abandons the remaining broadcast planes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_wr_acc && bus.i_msb && w_waddr_ok) begin
                r_mem[bus.i_waddr] <= (bus.i_wdata & ~w_bitmask) | (r_mem[bus.i_waddr] & w_bitmask);
            end
            if (w_bcast_act && w_pa_ok) begin
                r_mem[w_pa_idx] <= (w_bcast_word & ~w_bbitmask) | (r_mem[w_pa_idx] & w_bbitmask);
            end
        end
    end

    // Broadcast sequencer and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_wr_req && r_busy)                    r_err <= 1'b1;
            if (w_wr_acc && bus.i_msb && !w_waddr_ok)  r_err <= 1'b1;
            if (w_bcast_act && !w_pa_ok)               r_err <= 1'b1;
            if (!bus.i_csb && !w_raddr_ok)             r_err <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_wr_acc && !bus.i_msb) begin
                        r_base  <= bus.i_waddr;
                        r_bdata <= bus.i_wdata;
                        r_bmask <= bus.i_wordmask;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_BCAST;
                    end
                end
                S_BCAST: begin
                    if (r_idx == IW'(BCAST_PLANES - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read pipeline. Memory is sampled before this edge's write lands (read-first).
    // Each stage only loads data when its input is valid, so the output stage
    // holds the last returned word through idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pv <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pd[i] <= '0;
        end else begin
            r_pv[0] <= !bus.i_csb;
            if (!bus.i_csb) r_pd[0] <= w_raddr_ok ? r_mem[bus.i_raddr] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                if (r_pv[i-1]) r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign bus.o_rdata  = r_pd[RD_LAT-1];
    assign bus.o_rvalid = r_pv[RD_LAT-1];
    assign bus.o_busy   = r_busy;
    assign bus.o_err    = r_err;

    // Simulation backdoor: direct memory access, pipeline state untouched.
    task automatic load_act(input logic [AW-1:0] index, input logic [W-1:0] data);
        r_mem[index] <= data;
    endtask

    task automatic reset_sram();
        for (int i = 0; i < DEPTH; i++) r_mem[AW'(i)] <= 'x;
    endtask
endmodule

// File: tb/tb_act_sram_bcast_seq.sv
// tb/tb_act_sram_bcast_seq.sv - directed bench for act_sram_bcast_seq at read latency 1 and 2
module tb_act_sram_bcast_seq;
    localparam int W  = 48;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          csb = 1'b1;
    logic          wsb = 1'b1;
    logic          msb = 1'b1;
    logic [3:0]    wordmask = '0;
    logic [W-1:0]  wdata = '0;
    logic [AW-1:0] waddr = '0;
    logic [AW-1:0] raddr = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    act_sram_bcast_seq_if #(.LANES(4), .W(W), .AW(AW)) if1 ();
    act_sram_bcast_seq_if #(.LANES(4), .W(W), .AW(AW)) if2 ();

    assign if1.i_csb = csb;  assign if2.i_csb = csb;
    assign if1.i_wsb = wsb;  assign if2.i_wsb = wsb;
    assign if1.i_msb = msb;  assign if2.i_msb = msb;
    assign if1.i_wordmask = wordmask;  assign if2.i_wordmask = wordmask;
    assign if1.i_wdata = wdata;  assign if2.i_wdata = wdata;
    assign if1.i_waddr = waddr;  assign if2.i_waddr = waddr;
    assign if1.i_raddr = raddr;  assign if2.i_raddr = raddr;

    act_sram_bcast_seq #(.RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    act_sram_bcast_seq #(.RD_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        csb = 1'b1; wsb = 1'b1; msb = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        raddr = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [W-1:0] d);
        u_dut1.load_act(a, d);
        u_dut2.load_act(a, d);
    endtask

    // One read; dut1 result after one edge, dut2 result after the second.
    task automatic rd(input logic [AW-1:0] a, output logic [W-1:0] d1, output logic v1,
                      output logic [W-1:0] d2, output logic v2);
        csb = 1'b0; wsb = 1'b1; raddr = a;
        tick();
        d1 = if1.o_rdata; v1 = if1.o_rvalid;
        csb = 1'b1;
        tick();
        d2 = if2.o_rdata; v2 = if2.o_rvalid;
    endtask

    // Issue a broadcast and count the cycles busy is seen high (bounded).
    task automatic bcast(input logic [AW-1:0] base, input logic [W-1:0] d, input logic [3:0] m,
                         output int cyc);
        csb = 1'b0; wsb = 1'b0; msb = 1'b0; waddr = base; wdata = d; wordmask = m;
        tick();
        idle_inputs();
        cyc = 0;
        while (if1.o_busy === 1'b1 && cyc < 20) begin
            cyc++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (if1.o_rvalid !== 1'b0 || if1.o_rdata !== '0) begin bad++; $display("FAIL reset_rd1: got v=%b d=%h expected v=0 d=0", if1.o_rvalid, if1.o_rdata); end
        total++; if (if2.o_rvalid !== 1'b0 || if2.o_rdata !== '0) begin bad++; $display("FAIL reset_rd2: got v=%b d=%h expected v=0 d=0", if2.o_rvalid, if2.o_rdata); end
        total++; if (if1.o_busy !== 1'b0 || if1.o_err !== 1'b0) begin bad++; $display("FAIL reset_flags: got busy=%b err=%b expected 0 0", if1.o_busy, if1.o_err); end
        rst = 1'b0;
        tick();
        total++; if (if1.o_rvalid !== 1'b0) begin bad++; $display("FAIL idle_rvalid: got %b expected 0", if1.o_rvalid); end
    endtask

    task automatic test_normal_write();
        logic [W-1:0] d1, d2; logic v1, v2;
        load(18'd10, 48'h111222333444);
        csb = 1'b0; wsb = 1'b0; msb = 1'b1; waddr = 18'd10; raddr = 18'd0;
        wdata = 48'hAAABBBCCCDDD; wordmask = 4'b0101;
        tick();
        idle_inputs();
        rd(18'd10, d1, v1, d2, v2);
        total++; if (v1 !== 1'b1 || d1 !== 48'hAAA222CCC444) begin bad++; $display("FAIL nw_rd1: got v=%b d=%h expected v=1 d=aaa222ccc444", v1, d1); end
        total++; if (v2 !== 1'b1 || d2 !== 48'hAAA222CCC444) begin bad++; $display("FAIL nw_rd2: got v=%b d=%h expected v=1 d=aaa222ccc444", v2, d2); end
        total++; if (if1.o_rvalid !== 1'b0 || if1.o_rdata !== 48'hAAA222CCC444) begin bad++; $display("FAIL nw_hold: got v=%b d=%h expected v=0 d=aaa222ccc444", if1.o_rvalid, if1.o_rdata); end
    endtask

    task automatic test_read_first();
        logic [W-1:0] d1, d2; logic v1, v2;
        csb = 1'b0; wsb = 1'b0; msb = 1'b1; waddr = 18'd10; raddr = 18'd10;
        wdata = 48'h123456789ABC; wordmask = 4'b0000;
        tick();
        d1 = if1.o_rdata;
        idle_inputs();
        tick();
        d2 = if2.o_rdata;
        total++; if (d1 !== 48'hAAA222CCC444) begin bad++; $display("FAIL rf_old1: got %h expected aaa222ccc444", d1); end
        total++; if (d2 !== 48'hAAA222CCC444) begin bad++; $display("FAIL rf_old2: got %h expected aaa222ccc444", d2); end
        rd(18'd10, d1, v1, d2, v2);
        total++; if (v1 !== 1'b1 || d1 !== 48'h123456789ABC) begin bad++; $display("FAIL rf_new: got v=%b d=%h expected v=1 d=123456789abc", v1, d1); end
    endtask

    task automatic test_bcast();
        logic [W-1:0] d1, d2; logic v1, v2; int cyc;
        logic [AW-1:0] addrs [4] = '{18'd5, 18'd3254, 18'd6503, 18'd9752};
        logic [W-1:0]  exps  [4] = '{48'h001001001001, 48'h002002002002, 48'h003003003003, 48'h004004004004};
        bcast(18'd5, 48'h001002003004, 4'b0000, cyc);
        total++; if (cyc !== 4) begin bad++; $display("FAIL bc_busy: got %0d cycles expected 4", cyc); end
        for (int i = 0; i < 4; i++) begin
            rd(addrs[i], d1, v1, d2, v2);
            total++; if (d1 !== exps[i] || d2 !== exps[i]) begin bad++; $display("FAIL bc_plane%0d: got %h/%h expected %h", i, d1, d2, exps[i]); end
        end
    endtask

    task automatic test_bcast_mask();
        logic [W-1:0] d1, d2; logic v1, v2; int cyc;
        load(18'd5, 48'hF00000000000);
        load(18'd3254, 48'hE00000000000);
        bcast(18'd5, 48'h001002003004, 4'b1000, cyc);
        total++; if (cyc !== 4) begin bad++; $display("FAIL bm_busy: got %0d cycles expected 4", cyc); end
        rd(18'd5, d1, v1, d2, v2);
        total++; if (d1 !== 48'hF00001001001) begin bad++; $display("FAIL bm_plane0: got %h expected f00001001001", d1); end
        rd(18'd3254, d1, v1, d2, v2);
        total++; if (d1 !== 48'hE00002002002) begin bad++; $display("FAIL bm_plane1: got %h expected e00002002002", d1); end
        total++; if (if1.o_err !== 1'b0) begin bad++; $display("FAIL bm_noerr: got err=%b expected 0", if1.o_err); end
    endtask

    task automatic test_write_while_busy();
        logic [W-1:0] d1, d2; logic v1, v2; int cyc;
        load(18'd20, 48'h555555555555);
        csb = 1'b0; wsb = 1'b0; msb = 1'b0; waddr = 18'd100; wdata = 48'h00A00B00C00D; wordmask = 4'b0000;
        tick();
        idle_inputs();
        tick();
        csb = 1'b0; wsb = 1'b0; msb = 1'b1; waddr = 18'd20; wdata = 48'hFFFFFFFFFFFF;
        tick();
        idle_inputs();
        total++; if (if1.o_err !== 1'b1 || if2.o_err !== 1'b1) begin bad++; $display("FAIL wb_err: got %b/%b expected 1", if1.o_err, if2.o_err); end
        cyc = 0;
        while (if1.o_busy === 1'b1 && cyc < 20) begin cyc++; tick(); end
        total++; if (cyc !== 2) begin bad++; $display("FAIL wb_busy_rest: got %0d cycles expected 2", cyc); end
        rd(18'd20, d1, v1, d2, v2);
        total++; if (d1 !== 48'h555555555555) begin bad++; $display("FAIL wb_dropped: got %h expected 555555555555", d1); end
        rd(18'd9847, d1, v1, d2, v2);
        total++; if (d1 !== 48'h00D00D00D00D) begin bad++; $display("FAIL wb_last_plane: got %h expected 00d00d00d00d", d1); end
        repeat (10) tick();
        total++; if (if1.o_err !== 1'b1) begin bad++; $display("FAIL wb_sticky: got err=%b expected 1", if1.o_err); end
    endtask

    task automatic test_oob_bcast();
        logic [W-1:0] d1, d2; logic v1, v2; int cyc;
        do_reset();
        total++; if (if1.o_err !== 1'b0) begin bad++; $display("FAIL ob_err_clr: got err=%b expected 0", if1.o_err); end
        load(18'd207000, 48'h0);
        bcast(18'd207000, 48'h007008009010, 4'b0000, cyc);
        total++; if (cyc !== 4) begin bad++; $display("FAIL ob_busy: got %0d cycles expected 4", cyc); end
        total++; if (if1.o_err !== 1'b1) begin bad++; $display("FAIL ob_err: got err=%b expected 1", if1.o_err); end
        rd(18'd207000, d1, v1, d2, v2);
        total++; if (d1 !== 48'h007007007007) begin bad++; $display("FAIL ob_plane0: got %h expected 007007007007", d1); end
    endtask

    task automatic test_reset_mid_bcast();
        logic [W-1:0] d1, d2; logic v1, v2;
        do_reset();
        load(18'd300, 48'h999999999999);
        load(18'd3549, 48'h999999999999);
        load(18'd6798, 48'h999999999999);
        load(18'd10047, 48'h999999999999);
        csb = 1'b0; wsb = 1'b0; msb = 1'b0; waddr = 18'd300; wdata = 48'h001002003004; wordmask = 4'b0000;
        tick();
        idle_inputs();
        tick();
        csb = 1'b0; raddr = 18'd300;
        tick();
        total++; if (if1.o_rdata !== 48'h001001001001) begin bad++; $display("FAIL rm_rd1: got %h expected 001001001001", if1.o_rdata); end
        csb = 1'b1; rst = 1'b1;
        tick();
        total++; if (if1.o_busy !== 1'b0 || if2.o_rvalid !== 1'b0 || if1.o_rvalid !== 1'b0) begin bad++; $display("FAIL rm_after_rst: got busy=%b rv1=%b rv2=%b expected 0 0 0", if1.o_busy, if1.o_rvalid, if2.o_rvalid); end
        rst = 1'b0;
        tick();
        total++; if (if2.o_rvalid !== 1'b0) begin bad++; $display("FAIL rm_stale: got rvalid=%b expected 0", if2.o_rvalid); end
        rd(18'd300, d1, v1, d2, v2);
        total++; if (d1 !== 48'h001001001001 || d2 !== 48'h001001001001) begin bad++; $display("FAIL rm_plane0: got %h/%h expected 001001001001", d1, d2); end
        rd(18'd3549, d1, v1, d2, v2);
        total++; if (d1 !== 48'h002002002002) begin bad++; $display("FAIL rm_plane1: got %h expected 002002002002", d1); end
        rd(18'd6798, d1, v1, d2, v2);
        total++; if (d1 !== 48'h999999999999) begin bad++; $display("FAIL rm_plane2: got %h expected 999999999999", d1); end
        rd(18'd10047, d1, v1, d2, v2);
        total++; if (d1 !== 48'h999999999999) begin bad++; $display("FAIL rm_plane3: got %h expected 999999999999", d1); end
    endtask

    task automatic test_oob_read();
        logic [W-1:0] d1, d2; logic v1, v2;
        do_reset();
        rd(18'd210000, d1, v1, d2, v2);
        total++; if (v1 !== 1'b1 || d1 !== '0) begin bad++; $display("FAIL or_rd1: got v=%b d=%h expected v=1 d=0", v1, d1); end
        total++; if (v2 !== 1'b1 || d2 !== '0) begin bad++; $display("FAIL or_rd2: got v=%b d=%h expected v=1 d=0", v2, d2); end
        total++; if (if1.o_err !== 1'b1) begin bad++; $display("FAIL or_err: got err=%b expected 1", if1.o_err); end
    endtask

    initial begin
        test_reset();
        test_normal_write();
        test_read_first();
        test_bcast();
        test_bcast_mask();
        test_write_while_busy();
        test_oob_bcast();
        test_reset_mid_bcast();
        test_oob_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/act_sram_bcast_seq.md
Name: act_sram_bcast_seq

Overview:
Parametrised behavioural activation SRAM model for the layer-buffer testbench and simulation flow. It is the successor to the single-cycle 4-plane activation SRAM. Normal mode performs lane-masked word writes. Broadcast mode writes one activation per plane across BCAST_PLANES channel planes, serialised one plane per cycle by an internal sequencer, with a correct per-plane masked merge. Reads go through a configurable-latency pipeline with a valid strobe, and an error flag reports out-of-range accesses and dropped writes.

Parameters:
DEPTH, 207936, number of words
CH_NUM, 1, channels per word
ACT_PER_ADDR, 4, activations per channel per word
BW_PER_ACT, 12, bits per activation
PLANE_STRIDE, 3249, address distance between channel planes (57*57)
BCAST_PLANES, 4, planes written per broadcast; must be 1..LANES, where LANES = CH_NUM*ACT_PER_ADDR
RD_LAT, 1, read latency in cycles; must be >= 1
(derived) W = LANES*BW_PER_ACT; AW = clog2(DEPTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
csb  in  1  chip select, active low
wsb  in  1  write enable, active low
msb  in  1  mode: 1 = normal write, 0 = broadcast write
wordmask  in  LANES  per-lane keep mask; 1 = keep old lane, 0 = write lane
wdata  in  W  write data; lane k = bits [(k+1)*BW_PER_ACT-1 : k*BW_PER_ACT]
waddr  in  AW  write address (base address in broadcast mode)
raddr  in  AW  read address
rdata  out  W  read data
rvalid  out  1  rdata valid strobe
busy  out  1  broadcast sequence in progress
err  out  1  sticky error flag

Behaviour:
- Reset, synchronous and active-high: rdata=0, rvalid=0, busy=0, err=0, read pipeline flushed, sequencer forced to IDLE. Memory contents are not cleared by reset.
- Write acceptance: a write is accepted when csb=0, wsb=0 and busy=0.
- Normal write (msb=1): at the accepting edge, mem[waddr] = (wdata & ~bitmask) | (mem[waddr] & bitmask). bitmask expands each wordmask bit to BW_PER_ACT bits.
- Broadcast accept (msb=0): latch waddr, wdata and wordmask; go IDLE->BCAST with idx=0. No memory write happens at the accept edge.
- Broadcast sequence, BCAST state: busy=1. Each edge writes plane address pa = base + idx*PLANE_STRIDE.
  - Every unmasked lane of mem[pa] receives the activation taken from latched lane (LANES-1-idx), so plane 0 takes the MSB lane.
  - Masked lanes keep mem[pa]'s own old value.
  - idx then increments. After idx = BCAST_PLANES-1 is written, go back to IDLE.
  - busy is therefore high for exactly BCAST_PLANES cycles, and a new write can be accepted on the first cycle busy=0.
- Once started, the sequence continues regardless of csb, wsb and msb.
- Write attempted while busy=1 (csb=0, wsb=0): dropped, err<=1.
- Out-of-range write, normal or any broadcast plane, with address >= DEPTH: that word is not written, err<=1. The remaining in-range planes are still written.
- Read: when csb=0, raddr is sampled at the edge. Reads are allowed during busy and in the same cycle as a write.
  - Read-first: a read and a write to the same address on the same edge returns the pre-write data.
  - rdata and rvalid appear RD_LAT edges after sampling. With RD_LAT=1, data is visible after the next edge.
  - Back-to-back reads are fully pipelined: one result per cycle.
  - rvalid=0 for cycles with no read; rdata then holds its last value.
- Out-of-range read: rdata=0, rvalid=1, err<=1.
- err is sticky: it is cleared only by rst.
- Reset mid-broadcast: the remaining planes are abandoned, and planes already written keep their new data. busy=0 after the reset edge. Read results in flight are discarded.
- Simulation backdoor: task load_act(index, data) writes mem directly. Task reset_sram sets every word to X. Neither task touches the pipeline state.

Test Plan:
1. Preload mem[10]=0x111222333444; normal write waddr=10, wdata=0xAAABBBCCCDDD, wordmask=4'b0101; read 10 next cycle -> rvalid 1 cycle later, rdata=0xAAA222CCC444.
2. Broadcast base=5, wdata=0x001002003004, mask=0000 -> busy high 4 cycles; mem[5]=0x001001001001, mem[3254]=0x002002002002, mem[6503]=0x003003003003, mem[9752]=0x004004004004.
3. Preload mem[5]=0xF00000000000 and mem[3254]=0xE00000000000; broadcast base=5, mask=1000, wdata=0x001002003004 -> mem[5]=0xF00001001001 and mem[3254]=0xE00002002002 (each plane keeps its own lane 3).
4. Issue a normal write to addr 20 during busy cycle 2 of a broadcast -> mem[20] unchanged, err=1 and stays 1 until rst.
5. Broadcast base=207000 -> mem[207000] written; planes at 210249, 213498 and 216747 skipped; err=1; busy still lasts 4 cycles.
6. Assert rst for 1 cycle after 2 planes are written, with RD_LAT=2 and a read in flight -> planes 2-3 unchanged, busy=0 and rvalid=0 after the edge, and no stale rvalid afterwards.
